// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the write-back queue
package wb_pkg;

    localparam int REG_COUNT_DEF = 32;
    localparam int REG_WIDTH_DEF = 32;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AW_DEF = $clog2(REG_COUNT_DEF);

    typedef struct packed {
        logic [AW_DEF-1:0]        rd;
        logic [REG_WIDTH_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// rtl/wb_fwd_match.sv - youngest-match search over the queued entries
module wb_fwd_match #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int PW    = 2,
    parameter int CW    = 3
) (
    input  logic [DEPTH-1:0][AW-1:0] i_rd,
    input  logic [DEPTH-1:0][DW-1:0] i_data,
    input  logic [PW-1:0]            i_head,
    input  logic [CW-1:0]            i_count,
    input  logic [AW-1:0]            i_rs,
    output logic                     o_hit,
    output logic [DW-1:0]            o_data
);

    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PW'(i);
            if ((CW'(i) < i_count) && (i_rs != '0) && (i_rd[w_idx] == i_rs)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order write-back FIFO with register forwarding
module writeback_queue
    import wb_pkg::*;
#(
    parameter  int REG_COUNT = REG_COUNT_DEF,
    parameter  int REG_WIDTH = REG_WIDTH_DEF,
    parameter  int DEPTH     = 4,
    localparam int AW        = addr_width(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [AW-1:0]        alu_rd,
    input  logic [REG_WIDTH-1:0] alu_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [AW-1:0]        ld_rd,
    input  logic [REG_WIDTH-1:0] ld_data,
    output logic                 we3,
    output logic [AW-1:0]        ad3,
    output logic [REG_WIDTH-1:0] wd3,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [REG_WIDTH-1:0] fwd1_data,
    output logic [REG_WIDTH-1:0] fwd2_data,
    output logic                 full,
    output logic                 empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_DEPTH_M1 = CW'(DEPTH - 1);

    logic [DEPTH-1:0][AW-1:0]        r_rd;
    logic [DEPTH-1:0][REG_WIDTH-1:0] r_data;
    logic [PW-1:0]                   r_head;
    logic [PW-1:0]                   r_tail;
    logic [CW-1:0]                   r_count;

    logic          w_alu_acc;
    logic          w_ld_acc;
    logic          w_alu_enq;
    logic          w_ld_enq;
    logic          w_pop;
    logic [PW-1:0] w_ld_ptr;
    logic [CW-1:0] w_count_next;

    // Ready looks only at the registered count; a same-cycle pop never adds credit.
    assign alu_ready = (r_count < C_DEPTH);
    assign ld_ready  = alu_valid ? (r_count < C_DEPTH_M1) : (r_count < C_DEPTH);
    assign full      = (r_count == C_DEPTH);
    assign empty     = (r_count == '0);

    assign w_alu_acc = alu_valid && alu_ready;
    assign w_ld_acc  = ld_valid && ld_ready;
    assign w_alu_enq = w_alu_acc && (alu_rd != '0);
    assign w_ld_enq  = w_ld_acc && (ld_rd != '0);
    assign w_pop     = !empty;
    assign w_ld_ptr  = r_tail + PW'(w_alu_enq);

    assign w_count_next = r_count + CW'(w_alu_enq) + CW'(w_ld_enq) - CW'(w_pop);

    assign we3 = w_pop && !rst;
    assign ad3 = empty ? '0 : r_rd[r_head];
    assign wd3 = empty ? '0 : r_data[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_tail  <= r_tail + PW'(w_alu_enq) + PW'(w_ld_enq);
            r_count <= w_count_next;
        end
    end

    // The ALU result is older than a same-cycle load, so it takes the lower slot.
    always_ff @(posedge clk) begin
        if (w_alu_enq) begin
            r_rd[r_tail]   <= alu_rd;
            r_data[r_tail] <= alu_data;
        end
        if (w_ld_enq) begin
            r_rd[w_ld_ptr]   <= ld_rd;
            r_data[w_ld_ptr] <= ld_data;
        end
    end

    wb_fwd_match #(
        .AW(AW), .DW(REG_WIDTH), .DEPTH(DEPTH), .PW(PW), .CW(CW)
    ) u_fwd1 (
        .i_rd(r_rd), .i_data(r_data), .i_head(r_head), .i_count(r_count),
        .i_rs(rs1), .o_hit(fwd1_hit), .o_data(fwd1_data)
    );

    wb_fwd_match #(
        .AW(AW), .DW(REG_WIDTH), .DEPTH(DEPTH), .PW(PW), .CW(CW)
    ) u_fwd2 (
        .i_rd(r_rd), .i_data(r_data), .i_head(r_head), .i_count(r_count),
        .i_rs(rs2), .o_hit(fwd2_hit), .o_data(fwd2_data)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue
module tb_writeback_queue;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, ld_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_rd, ld_rd, rs1, rs2, ad3;
    logic [31:0] alu_data, ld_data, wd3, fwd1_data, fwd2_data;
    logic        we3, fwd1_hit, fwd2_hit, full, empty;

    int        n_cmp = 0;
    int        n_bad = 0;
    bit        a_acc, l_acc;
    wb_entry_t sb[$];

    always #5 clk = ~clk;

    writeback_queue dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .we3(we3), .ad3(ad3), .wd3(wd3),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void fwd_model(input logic [4:0] rs, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = 0; i < sb.size(); i++) begin
            if (rs != 0 && sb[i].rd == rs) begin
                hit = 1'b1;
                d   = sb[i].data;
            end
        end
    endfunction

    task automatic cyc();
        wb_entry_t   e;
        int          n;
        bit          h;
        logic [31:0] d;
        @(negedge clk);
        a_acc = 1'b0;
        l_acc = 1'b0;
        if (rst) begin
            chk("we3_in_rst", we3, 0);
        end else begin
            n = sb.size();
            chk("empty", empty, n == 0);
            chk("full", full, n == 4);
            chk("alu_ready", alu_ready, n < 4);
            chk("ld_ready", ld_ready, alu_valid ? (n < 3) : (n < 4));
            fwd_model(rs1, h, d);
            chk("fwd1_hit", fwd1_hit, h);
            chk("fwd1_data", fwd1_data, d);
            fwd_model(rs2, h, d);
            chk("fwd2_hit", fwd2_hit, h);
            chk("fwd2_data", fwd2_data, d);
            chk("we3", we3, n != 0);
            if (n != 0) begin
                e = sb.pop_front();
                chk("ad3", ad3, e.rd);
                chk("wd3", wd3, e.data);
            end else begin
                chk("ad3_idle", ad3, 0);
                chk("wd3_idle", wd3, 0);
            end
            a_acc = alu_valid && (n < 4);
            l_acc = ld_valid && (alu_valid ? (n < 3) : (n < 4));
            if (a_acc && alu_rd != 0) begin
                e.rd = alu_rd; e.data = alu_data; sb.push_back(e);
            end
            if (l_acc && ld_rd != 0) begin
                e.rd = ld_rd; e.data = ld_data; sb.push_back(e);
            end
        end
        @(posedge clk);
        if (rst) sb.delete();
        #1;
    endtask

    task automatic run(input int n, input int pa, input int pl);
        for (int k = 0; k < n; k++) begin
            if (!alu_valid && $urandom_range(0, 99) < pa) begin
                alu_valid = 1'b1;
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!ld_valid && $urandom_range(0, 99) < pl) begin
                ld_valid = 1'b1;
                ld_rd    = 5'($urandom_range(0, 7));
                ld_data  = $urandom;
            end
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            cyc();
            if (a_acc) alu_valid = 1'b0;
            if (l_acc) ld_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            if (!alu_valid && !ld_valid && sb.size() == 0) break;
            run(1, 0, 0);
        end
        chk("drained_empty", empty, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
        alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0; rs1 = '0; rs2 = '0;
        #1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        cyc();
        alu_valid = 1'b0;
        cyc(); cyc();

        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
        ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'hB;
        rs1 = 5'd3; rs2 = 5'd3;
        cyc();
        alu_valid = 1'b0; ld_valid = 1'b0;
        cyc(); cyc(); cyc();

        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        rs1 = 5'd0; rs2 = 5'd0;
        cyc();
        alu_valid = 1'b0;
        cyc(); cyc();

        run(12, 100, 100);
        drain();

        run(40, 70, 50);
        drain();

        rs1 = 5'd1; rs2 = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h101;
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h202;
        cyc();
        alu_rd = 5'd3; alu_data = 32'h303;
        ld_rd  = 5'd4; ld_data  = 32'h404;
        cyc();
        alu_valid = 1'b0; ld_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_fwd1", fwd1_hit, 0);
        chk("post_rst_empty", empty, 1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffered write-back stage that sits directly upstream of the register file write port (`we3`/`ad3`/`wd3`). Collects results from the single-cycle ALU path and the variable-latency load path and queues them in program order in a small FIFO. Drains one entry per cycle into the register file. Provides read-after-write forwarding for queued but not-yet-committed results, so the asynchronous register file reads plus this block always return the newest value.

## Interface

Parameters
- `REG_COUNT`, 32: architectural registers; address width `AW = $clog2(REG_COUNT)`.
- `REG_WIDTH`, 32: data width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result offered this cycle.
- `alu_ready` out 1: ALU result will be accepted.
- `alu_rd` in AW: ALU destination register.
- `alu_data` in REG_WIDTH: ALU result.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: load result will be accepted.
- `ld_rd` in AW: load destination register.
- `ld_data` in REG_WIDTH: load result.
- `we3` out 1: register file write enable.
- `ad3` out AW: register file write address.
- `wd3` out REG_WIDTH: register file write data.
- `rs1`, `rs2` in AW: operand addresses being read from the register file this cycle.
- `fwd1_hit`, `fwd2_hit` out 1: queued value overrides register file read for rs1/rs2.
- `fwd1_data`, `fwd2_data` out REG_WIDTH: forwarded values.
- `full`, `empty` out 1: FIFO status from registered count.

## Operation

State
- `DEPTH` entries of {rd, data}, head pointer, tail pointer, count (0..DEPTH).
- Pointers wrap modulo DEPTH.

Accept
- A transfer occurs when `valid && ready`.
- `alu_ready = (count < DEPTH)`.
- `ld_ready = (count < DEPTH-1)` when `alu_valid`, else `(count < DEPTH)`.
- Ready depends only on the registered count and `alu_valid`. A same-cycle drain does not add credit.
- Simultaneous accept of both: ALU entry is written at tail and load entry at tail+1. ALU is treated as older.
- Valid/data must stay stable until accepted. A source may not retract valid before acceptance.

Drop
- Accepted results with rd == 0 are consumed (handshake completes) but not enqueued. They do not affect count.

Drain
- `we3 = !empty`. `ad3`/`wd3` come from the head entry (combinational from registers).
- The head pops on every rising edge where `!empty`. The register file commits that same edge.
- Count update: +enqueued −popped. Enqueue and pop may occur in the same cycle.

Forwarding
- For rs1 (rs2 identical): scan all valid entries, head through head+count−1.
- `fwd1_hit` = 1 if any entry matches rs1 and rs1 ≠ 0.
- `fwd1_data` = data of the youngest matching entry.
- An entry being written this cycle (the head) still forwards, because the register file has not yet updated.
- No hit: `fwd*_data = 0`.

Reset
- Count, head, and tail are 0. Entry contents are don't-care.
- Outputs after reset: `we3=0`, `ad3=0`, `wd3=0`, `fwd*_hit=0`, `fwd*_data=0`, `empty=1`, `full=0`, `alu_ready=1`, `ld_ready=1`.
- `ad3`/`wd3` are forced to 0 when empty.
- Reset mid-operation discards all queued entries. Nothing is written on the reset edge (`we3` is gated by `!rst`).

## Timing

- Enqueue-to-commit latency:
  - Empty queue: accepted at edge N, `we3` high during cycle N→N+1, register file written at edge N+1.
  - Otherwise: add one cycle per older entry.
- Throughput: 1 commit per cycle. Up to 2 accepts per cycle.
- Forwarding and ready are combinational within the cycle. Status flags derive from registered count only.
- Full: `alu_ready=0`, `ld_ready=0`. The head still drains, so the queue is not full on the next cycle.
- Empty with both inputs valid: both accepted, and neither is written to the register file in that cycle.

## Structure

- Shared package `wb_pkg`:
  - `wb_entry_t` struct {rd, data}.
  - `REG_COUNT`/`REG_WIDTH` defaults.
  - `AW` localparam helper.
- One natural sub-module: `wb_fwd_match`. Combinational youngest-match search over the entry array, instantiated twice (rs1, rs2).

## Test plan

- Reset, then idle: `we3=0`, `empty=1`, both readies 1. ALU x5=0x11 → `we3=1`, `ad3=5`, `wd3=0x11` next cycle. `empty=1` after the following edge.
- Both valid at count=0: ALU x3=0xA and load x3=0xB. Commits x3=0xA, then x3=0xB. `fwd1_hit` with rs1=3 returns 0xB while both are queued.
- Fill: hold `we3` drain, ALU back-to-back with DEPTH=4. Assert `alu_ready` tracks `count<4` and `ld_ready=0` whenever `alu_valid` and count=3.
- rd=0 results: ALU x0=0xFFFF accepted, `we3` never asserts, count unchanged. rs1=0 → `fwd1_hit=0`.
- Pointer wrap: 10 consecutive mixed accepts with random load stalls. The commit order equals the accept order (ALU before load on the same cycle) and the data is intact.
- Reset asserted with 3 entries queued: no write on the reset edge, then `empty=1` and `fwd*_hit=0`.
